// File: rtl/rename_ckpt_if.sv
// Decode -> rename -> dispatch handshake: one instruction request and its renamed result per cycle.
interface rename_ckpt_if #(
  parameter int A_IDX_W = 5,
  parameter int P_IDX_W = 6,
  parameter int T_W     = 2
);
  logic               in_valid_i;
  logic               in_is_branch_i;
  logic               in_rs1_valid_i;
  logic               in_rs2_valid_i;
  logic [A_IDX_W-1:0] in_rs1_idx_i;
  logic [A_IDX_W-1:0] in_rs2_idx_i;
  logic               in_rd_valid_i;
  logic [A_IDX_W-1:0] in_rd_idx_i;

  logic               stall_o;
  logic               out_valid_o;
  logic [P_IDX_W-1:0] out_rs1_idx_o;
  logic [P_IDX_W-1:0] out_rs2_idx_o;
  logic               out_rs1_ready_o;
  logic               out_rs2_ready_o;
  logic               out_rd_valid_o;
  logic [P_IDX_W-1:0] out_rd_idx_o;
  logic [P_IDX_W-1:0] out_rd_old_idx_o;
  logic [T_W-1:0]     out_br_tag_o;

  modport master (
    output in_valid_i, in_is_branch_i, in_rs1_valid_i, in_rs2_valid_i,
           in_rs1_idx_i, in_rs2_idx_i, in_rd_valid_i, in_rd_idx_i,
    input  stall_o, out_valid_o, out_rs1_idx_o, out_rs2_idx_o, out_rs1_ready_o,
           out_rs2_ready_o, out_rd_valid_o, out_rd_idx_o, out_rd_old_idx_o, out_br_tag_o
  );

  modport slave (
    input  in_valid_i, in_is_branch_i, in_rs1_valid_i, in_rs2_valid_i,
           in_rs1_idx_i, in_rs2_idx_i, in_rd_valid_i, in_rd_idx_i,
    output stall_o, out_valid_o, out_rs1_idx_o, out_rs2_idx_o, out_rs1_ready_o,
           out_rs2_ready_o, out_rd_valid_o, out_rd_idx_o, out_rd_old_idx_o, out_br_tag_o
  );
endinterface

// File: rtl/rename_ckpt.sv
// Register rename stage: RAT, ready table, circular free list and a ring of
// NUM_CKPT branch checkpoints restored on mispredict.
module rename_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int NUM_CKPT  = 4,
  parameter int A_IDX_W   = $clog2(ARCH_REGS),
  parameter int P_IDX_W   = $clog2(PHYS_REGS),
  parameter int T_W       = $clog2(NUM_CKPT)
) (
  input  logic               clk,
  input  logic               rst_ni,
  rename_ckpt_if.slave       rn,
  input  logic               wb_valid_i,
  input  logic [P_IDX_W-1:0] wb_idx_i,
  input  logic               free_valid_i,
  input  logic [P_IDX_W-1:0] free_idx_i,
  input  logic               br_valid_i,
  input  logic [T_W-1:0]     br_tag_i,
  input  logic               br_hit_i,
  output logic [T_W:0]       ckpt_cnt_o
);

  typedef logic [P_IDX_W-1:0] preg_t;
  typedef logic [P_IDX_W:0]   fptr_t;

  preg_t                rat_q       [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready_q;
  preg_t                free_list_q [PHYS_REGS];
  fptr_t                fl_head_q, fl_tail_q;

  preg_t                ckpt_rat_q  [NUM_CKPT][ARCH_REGS];
  fptr_t                ckpt_head_q [NUM_CKPT];
  logic [T_W-1:0]       ck_head_q, ck_tail_q;
  logic [T_W:0]         ck_cnt_q;

  logic [A_IDX_W-1:0]   rd_idx;
  logic [T_W-1:0]       br_age;
  logic                 br_active, flush, hit_rel;
  logic                 alloc_needed, fl_empty, ckpt_full;
  logic                 accept, alloc, take_ckpt, free_push;
  preg_t                new_preg, rs1_map, rs2_map;
  preg_t                rat_post    [ARCH_REGS];
  fptr_t                head_post;

  // A tag is live when its distance from the ring head is below the count.
  always_comb begin
    rd_idx       = rn.in_rd_idx_i;
    br_age       = br_tag_i - ck_head_q;
    br_active    = {1'b0, br_age} < ck_cnt_q;
    flush        = br_valid_i & ~br_hit_i & br_active;
    hit_rel      = br_valid_i & br_hit_i & br_active & (br_tag_i == ck_head_q);
    alloc_needed = rn.in_valid_i & rn.in_rd_valid_i & (rd_idx != '0);
    fl_empty     = (fl_tail_q == fl_head_q);
    ckpt_full    = (ck_cnt_q == (T_W+1)'(NUM_CKPT));
    rn.stall_o   = rn.in_valid_i & (flush | (alloc_needed & fl_empty) | (rn.in_is_branch_i & ckpt_full));
    accept       = rn.in_valid_i & ~rn.stall_o;
    alloc        = accept & alloc_needed;
    take_ckpt    = accept & rn.in_is_branch_i;
    free_push    = free_valid_i & (free_idx_i != '0);
    new_preg     = free_list_q[fl_head_q[P_IDX_W-1:0]];
    rs1_map      = rat_q[rn.in_rs1_idx_i];
    rs2_map      = rat_q[rn.in_rs2_idx_i];
    head_post    = alloc ? fl_head_q + fptr_t'(1) : fl_head_q;
  end

  // Mapping as seen after this instruction; also what a branch snapshots.
  always_comb begin
    for (int unsigned i = 0; i < ARCH_REGS; i++) rat_post[i] = rat_q[i];
    if (alloc) rat_post[rd_idx] = new_preg;
  end

  always_comb begin
    rn.out_valid_o      = 1'b0;
    rn.out_rs1_idx_o    = '0;
    rn.out_rs2_idx_o    = '0;
    rn.out_rs1_ready_o  = 1'b0;
    rn.out_rs2_ready_o  = 1'b0;
    rn.out_rd_valid_o   = 1'b0;
    rn.out_rd_idx_o     = '0;
    rn.out_rd_old_idx_o = '0;
    rn.out_br_tag_o     = '0;
    if (accept) begin
      rn.out_valid_o = 1'b1;
      if (rn.in_rs1_valid_i) begin
        rn.out_rs1_idx_o   = rs1_map;
        rn.out_rs1_ready_o = ready_q[rs1_map] | (wb_valid_i & (wb_idx_i == rs1_map));
      end
      if (rn.in_rs2_valid_i) begin
        rn.out_rs2_idx_o   = rs2_map;
        rn.out_rs2_ready_o = ready_q[rs2_map] | (wb_valid_i & (wb_idx_i == rs2_map));
      end
      rn.out_rd_valid_o = rn.in_rd_valid_i;
      if (alloc) begin
        rn.out_rd_idx_o     = new_preg;
        rn.out_rd_old_idx_o = rat_q[rd_idx];
      end
      if (rn.in_is_branch_i) rn.out_br_tag_o = ck_tail_q;
    end
  end

  assign ckpt_cnt_o = ck_cnt_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) rat_q[i] <= preg_t'(i);
      ready_q <= '1;
      for (int unsigned i = 0; i < PHYS_REGS; i++)
        free_list_q[i] <= (i < PHYS_REGS - ARCH_REGS) ? preg_t'(ARCH_REGS + i) : '0;
      fl_head_q <= '0;
      fl_tail_q <= fptr_t'(PHYS_REGS - ARCH_REGS);
      ck_head_q <= '0;
      ck_tail_q <= '0;
      ck_cnt_q  <= '0;
    end else begin
      if (flush) begin
        rat_q     <= ckpt_rat_q[br_tag_i];
        fl_head_q <= ckpt_head_q[br_tag_i];
      end else begin
        rat_q     <= rat_post;
        fl_head_q <= head_post;
      end

      if (wb_valid_i && (wb_idx_i != '0)) ready_q[wb_idx_i] <= 1'b1;
      if (alloc) ready_q[new_preg] <= 1'b0;

      if (free_push) begin
        free_list_q[fl_tail_q[P_IDX_W-1:0]] <= free_idx_i;
        fl_tail_q <= fl_tail_q + fptr_t'(1);
      end

      // Mispredict drops the tag itself and everything younger; the freed
      // tag becomes the next one handed out.
      if (flush) begin
        ck_tail_q <= br_tag_i;
        ck_cnt_q  <= {1'b0, br_age};
      end else begin
        if (hit_rel)   ck_head_q <= ck_head_q + 1'b1;
        if (take_ckpt) ck_tail_q <= ck_tail_q + 1'b1;
        ck_cnt_q <= ck_cnt_q + (T_W+1)'(take_ckpt) - (T_W+1)'(hit_rel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_ckpt) begin
      ckpt_rat_q[ck_tail_q]  <= rat_post;
      ckpt_head_q[ck_tail_q] <= head_post;
    end
  end

endmodule

// File: tb/tb_rename_ckpt.sv
// Directed plus random bench for rename_ckpt against a queue-based rename model.
module tb_rename_ckpt;
  localparam int AR = 32;
  localparam int PR = 64;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       wb_valid_i, free_valid_i, br_valid_i, br_hit_i;
  logic [5:0] wb_idx_i, free_idx_i;
  logic [1:0] br_tag_i;
  logic [2:0] ckpt_cnt_o;
  int         total = 0;
  int         bad   = 0;

  rename_ckpt_if #(.A_IDX_W(5), .P_IDX_W(6), .T_W(2)) rn ();

  rename_ckpt #(.ARCH_REGS(AR), .PHYS_REGS(PR), .NUM_CKPT(NC)) dut (
    .clk(clk), .rst_ni(rst_ni), .rn(rn),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i),
    .free_valid_i(free_valid_i), .free_idx_i(free_idx_i),
    .br_valid_i(br_valid_i), .br_tag_i(br_tag_i), .br_hit_i(br_hit_i),
    .ckpt_cnt_o(ckpt_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: free regs as a queue, allocation history, checkpoints as a tag queue.
  int m_rat [AR];
  bit m_ready [PR];
  int m_free[$], m_log[$], ckq[$], pend_reg[$], pend_seq[$];
  int ck_rat [NC][AR];
  int ck_len [NC];
  int ck_seq [NC];
  int next_tag, seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rn.in_valid_i = 0; rn.in_is_branch_i = 0;
    rn.in_rs1_valid_i = 0; rn.in_rs1_idx_i = 0;
    rn.in_rs2_valid_i = 0; rn.in_rs2_idx_i = 0;
    rn.in_rd_valid_i = 0; rn.in_rd_idx_i = 0;
    wb_valid_i = 0; wb_idx_i = 0; free_valid_i = 0; free_idx_i = 0;
    br_valid_i = 0; br_tag_i = 0; br_hit_i = 0;
  endtask

  task automatic ins(input bit br, input bit r1v, input int r1, input bit r2v, input int r2,
                     input bit rdv, input int rd);
    rn.in_valid_i = 1; rn.in_is_branch_i = br;
    rn.in_rs1_valid_i = r1v; rn.in_rs1_idx_i = 5'(r1);
    rn.in_rs2_valid_i = r2v; rn.in_rs2_idx_i = 5'(r2);
    rn.in_rd_valid_i = rdv;  rn.in_rd_idx_i = 5'(rd);
  endtask

  task automatic model_reset();
    for (int i = 0; i < AR; i++) m_rat[i] = i;
    for (int i = 0; i < PR; i++) m_ready[i] = 1;
    m_free.delete(); m_log.delete(); ckq.delete(); pend_reg.delete(); pend_seq.delete();
    for (int i = AR; i < PR; i++) m_free.push_back(i);
    next_tag = 0; seq = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    model_reset();
    #1;
    chk("rst_cnt", ckpt_cnt_o, 0);
    chk("rst_valid", rn.out_valid_o, 0);
    @(negedge clk);
    rst_ni = 1;
  endtask

  // Check the current cycle's outputs, advance the model, move to next negedge.
  task automatic cycle();
    int  pos, rd, r1, r2, bt, nw, e_r1, e_r2, e_rd, e_old, e_tag;
    bit  flush, alloc_n, stall, acc, e_r1r, e_r2r, e_rdv;
    #1;
    rd = rn.in_rd_idx_i; r1 = rn.in_rs1_idx_i; r2 = rn.in_rs2_idx_i; bt = br_tag_i;
    pos = -1;
    foreach (ckq[i]) if (ckq[i] == bt) pos = i;
    flush   = br_valid_i && !br_hit_i && pos >= 0;
    alloc_n = rn.in_valid_i && rn.in_rd_valid_i && rd != 0;
    stall   = rn.in_valid_i && (flush || (alloc_n && m_free.size() == 0) ||
                                (rn.in_is_branch_i && ckq.size() == NC));
    acc     = rn.in_valid_i && !stall;
    e_r1 = 0; e_r2 = 0; e_r1r = 0; e_r2r = 0; e_rdv = 0; e_rd = 0; e_old = 0; e_tag = 0;
    if (acc) begin
      if (rn.in_rs1_valid_i) begin
        e_r1 = m_rat[r1]; e_r1r = m_ready[e_r1] || (wb_valid_i && wb_idx_i == e_r1);
      end
      if (rn.in_rs2_valid_i) begin
        e_r2 = m_rat[r2]; e_r2r = m_ready[e_r2] || (wb_valid_i && wb_idx_i == e_r2);
      end
      e_rdv = rn.in_rd_valid_i;
      if (alloc_n) begin e_rd = m_free[0]; e_old = m_rat[rd]; end
      if (rn.in_is_branch_i) e_tag = next_tag;
    end
    chk("stall", rn.stall_o, stall);
    chk("valid", rn.out_valid_o, acc);
    chk("rs1_idx", rn.out_rs1_idx_o, e_r1);
    chk("rs1_rdy", rn.out_rs1_ready_o, e_r1r);
    chk("rs2_idx", rn.out_rs2_idx_o, e_r2);
    chk("rs2_rdy", rn.out_rs2_ready_o, e_r2r);
    chk("rd_valid", rn.out_rd_valid_o, e_rdv);
    chk("rd_idx", rn.out_rd_idx_o, e_rd);
    chk("rd_old", rn.out_rd_old_idx_o, e_old);
    chk("br_tag", rn.out_br_tag_o, e_tag);
    chk("ckpt_cnt", ckpt_cnt_o, ckq.size());

    if (wb_valid_i && wb_idx_i != 0) m_ready[wb_idx_i] = 1;
    if (acc && alloc_n) begin
      nw = m_free.pop_front();
      m_rat[rd] = nw; m_ready[nw] = 0; m_log.push_back(nw);
      pend_reg.push_back(e_old); pend_seq.push_back(seq);
    end
    if (br_valid_i && br_hit_i && ckq.size() > 0 && ckq[0] == bt) void'(ckq.pop_front());
    if (acc && rn.in_is_branch_i) begin
      ck_rat[e_tag] = m_rat; ck_len[e_tag] = m_log.size(); ck_seq[e_tag] = seq + 1;
      ckq.push_back(e_tag); next_tag = (e_tag + 1) % NC;
    end
    if (acc) seq++;
    if (flush) begin
      m_rat = ck_rat[bt];
      while (m_log.size() > ck_len[bt]) m_free.push_front(m_log.pop_back());
      while (ckq.size() > pos) void'(ckq.pop_back());
      while (pend_seq.size() > 0 && pend_seq[$] >= ck_seq[bt]) begin
        void'(pend_seq.pop_back()); void'(pend_reg.pop_back());
      end
      next_tag = bt;
    end
    if (free_valid_i && free_idx_i != 0) m_free.push_back(free_idx_i);
    @(negedge clk);
  endtask

  task automatic probe_rat();
    for (int i = 0; i < AR; i++) begin
      idle(); ins(0, 1, i, 0, 0, 0, 0); cycle();
    end
  endtask

  initial begin
    rst_ni = 1;
    #2;
    // 1: add x5,x1,x2 then x5 as a source
    do_reset();
    ins(0, 1, 1, 1, 2, 1, 5);
    #1;
    chk("t1_rs1", rn.out_rs1_idx_o, 1); chk("t1_rs2", rn.out_rs2_idx_o, 2);
    chk("t1_rd", rn.out_rd_idx_o, 32);  chk("t1_old", rn.out_rd_old_idx_o, 5);
    cycle();
    idle(); ins(0, 1, 5, 0, 0, 0, 0);
    #1; chk("t1_src", rn.out_rs1_idx_o, 32); chk("t1_srdy", rn.out_rs1_ready_o, 0);
    cycle();

    // 2: exhaust free list, free p5, reuse it
    do_reset();
    for (int i = 0; i < 32; i++) begin idle(); ins(0, 0, 0, 0, 0, 1, (i % 31) + 1); cycle(); end
    idle(); ins(0, 0, 0, 0, 0, 1, 7);
    #1; chk("t2_stall", rn.stall_o, 1); chk("t2_valid", rn.out_valid_o, 0);
    free_valid_i = 1; free_idx_i = 5;
    cycle();
    idle(); ins(0, 0, 0, 0, 0, 1, 7);
    #1; chk("t2_reuse", rn.out_rd_idx_o, 5);
    cycle();

    // 3: checkpoint ring full, hit on oldest frees a slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); ins(1, 0, 0, 0, 0, 0, 0); cycle();
      idle(); ins(0, 0, 0, 0, 0, 1, i + 1); cycle();
    end
    idle(); ins(1, 0, 0, 0, 0, 0, 0);
    #1; chk("t3_stall", rn.stall_o, 1); chk("t3_cnt", ckpt_cnt_o, 4);
    cycle();
    idle(); ins(1, 0, 0, 0, 0, 0, 0); br_valid_i = 1; br_tag_i = 0; br_hit_i = 1; cycle();
    idle(); ins(1, 0, 0, 0, 0, 0, 0);
    #1; chk("t3_tag", rn.out_br_tag_o, 0); chk("t3_acc", rn.out_valid_o, 1);
    cycle();

    // 4: mispredict on tag 1 with tags 0..2 live
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); ins(1, 0, 0, 0, 0, 1, 2 * i + 1); cycle();
      idle(); ins(0, 0, 0, 0, 0, 1, 2 * i + 2); cycle();
    end
    idle(); br_valid_i = 1; br_tag_i = 1; br_hit_i = 0; cycle();
    idle(); #1; chk("t4_cnt", ckpt_cnt_o, 1);
    ins(0, 0, 0, 0, 0, 1, 9);
    #1; chk("t4_re0", rn.out_rd_idx_o, 35);
    cycle();
    idle(); ins(0, 0, 0, 0, 0, 1, 10);
    #1; chk("t4_re1", rn.out_rd_idx_o, 36);
    cycle();
    probe_rat();

    // 5: same-cycle writeback bypass and mispredict priority over rename
    do_reset();
    for (int i = 1; i <= 9; i++) begin idle(); ins(0, 0, 0, 0, 0, 1, i); cycle(); end
    idle(); ins(0, 1, 9, 0, 0, 0, 0); wb_valid_i = 1; wb_idx_i = 40;
    #1; chk("t5_idx", rn.out_rs1_idx_o, 40); chk("t5_byp", rn.out_rs1_ready_o, 1);
    cycle();
    idle(); ins(1, 0, 0, 0, 0, 0, 0); cycle();
    idle(); ins(0, 0, 0, 0, 0, 1, 3); br_valid_i = 1; br_tag_i = 0; br_hit_i = 0;
    #1; chk("t5_stall", rn.stall_o, 1);
    cycle();
    probe_rat();

    // 6: reset mid branch window
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); ins(1, 0, 0, 0, 0, 1, i + 4); cycle();
    end
    do_reset();
    probe_rat();
    idle(); ins(0, 0, 0, 0, 0, 1, 12);
    #1; chk("t6_first", rn.out_rd_idx_o, 32);
    cycle();

    // random traffic with legal commits
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        ins($urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) begin wb_valid_i = 1; wb_idx_i = 6'($urandom_range(0, 63)); end
      if ($urandom_range(0, 3) == 0) begin
        br_valid_i = 1; br_tag_i = 2'($urandom_range(0, 3)); br_hit_i = $urandom_range(0, 3) != 0;
      end
      if (pend_reg.size() > 0 && (ckq.size() == 0 || pend_seq[0] < ck_seq[ckq[0]]) &&
          $urandom_range(0, 1) == 1) begin
        free_valid_i = 1; free_idx_i = 6'(pend_reg.pop_front()); void'(pend_seq.pop_front());
      end
      cycle();
    end
    probe_rat();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
